// File: rtl/dmem_responder_if.sv
// Load/store port between a requester (core or LSU) and the data-memory responder.
// The requester holds valid and the request fields until the transfer completes.
interface dmem_responder_if;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byte_enable;
    logic        ready;
    logic [31:0] rdata;

    modport master (
        output valid,
        output addr,
        output wdata,
        output byte_enable,
        input  ready,
        input  rdata
    );

    modport slave (
        input  valid,
        input  addr,
        input  wdata,
        input  byte_enable,
        output ready,
        output rdata
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised RAM behind a valid/ready load/store port.
// Aligned accesses take one beat; misaligned accesses take two (base word, then
// base+1 with wrap). Each beat presents the raw pre-write RAM word on rdata and
// commits the store lanes that fall into that word. A one-cycle HOLD strobe
// closes every completed request.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 1
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus
);
    localparam int unsigned AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  CNT_INIT    = 4'(LATENCY - 1);
    localparam bit          MULTI_CYCLE = (LATENCY > 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT0 = 3'd1,
        S_BEAT0 = 3'd2,
        S_WAIT1 = 3'd3,
        S_BEAT1 = 3'd4,
        S_HOLD  = 3'd5
    } state_t;

    // Backing store; intentionally never cleared by reset.
    logic [31:0] mem [DEPTH_WORDS];

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] base_q, base_d;
    logic [1:0]    off_q, off_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;
    logic          two_beat_q, two_beat_d;
    logic          ready_q, ready_d;
    logic [31:0]   rdata_q, rdata_d;

    logic [AW-1:0] req_base_s;
    logic [1:0]    req_off_s;
    logic [31:0]   req_wdata_s;
    logic [3:0]    req_be_s;
    logic          go0_s, go1_s;
    logic [3:0]    cnt_dec_s;
    logic [63:0]   lane_data_s;
    logic [7:0]    lane_be_s;
    logic          wr_en_s;
    logic [AW-1:0] beat_idx_s;
    logic [3:0]    wr_be_s;
    logic [31:0]   wr_data_s;
    logic          unused_addr_s;

    // Upper address bits are ignored by design; fold them into a sink.
    assign unused_addr_s = ^bus.addr;

    // Request fields: live inputs while accepting, captured copies for the rest of the request
    always_comb begin
        if (state_q == S_IDLE) begin
            req_base_s  = bus.addr[2 +: AW];
            req_off_s   = bus.addr[1:0];
            req_wdata_s = bus.wdata;
            req_be_s    = bus.byte_enable;
        end else begin
            req_base_s  = base_q;
            req_off_s   = off_q;
            req_wdata_s = wdata_q;
            req_be_s    = be_q;
        end
    end

    // Shift store lanes into the two-word window starting at the base word
    always_comb begin
        lane_data_s = {32'd0, req_wdata_s} << {req_off_s, 3'b000};
        lane_be_s   = {4'd0, req_be_s} << req_off_s;
    end

    // Next-state logic for the request sequencer
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        base_d     = base_q;
        off_d      = off_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        two_beat_d = two_beat_q;
        go0_s      = 1'b0;
        go1_s      = 1'b0;
        cnt_dec_s  = cnt_q - 4'd1;
        case (state_q)
            S_IDLE: begin
                if (bus.valid) begin
                    base_d     = req_base_s;
                    off_d      = req_off_s;
                    wdata_d    = req_wdata_s;
                    be_d       = req_be_s;
                    two_beat_d = (req_off_s != 2'd0);
                    cnt_d      = CNT_INIT;
                    if (MULTI_CYCLE) begin
                        state_d = S_WAIT0;
                    end else begin
                        state_d = S_BEAT0;
                        go0_s   = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT0, S_WAIT1: begin
                if (!bus.valid) begin
                    state_d = S_IDLE;
                end else if (cnt_dec_s == 4'd0) begin
                    cnt_d = cnt_dec_s;
                    if (state_q == S_WAIT0) begin
                        state_d = S_BEAT0;
                        go0_s   = 1'b1;
                    end else begin
                        state_d = S_BEAT1;
                        go1_s   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_dec_s;
                end
            end
            S_BEAT0: begin
                if (!bus.valid) begin
                    state_d = S_IDLE;
                end else if (two_beat_q) begin
                    cnt_d = CNT_INIT;
                    if (MULTI_CYCLE) begin
                        state_d = S_WAIT1;
                    end else begin
                        state_d = S_BEAT1;
                        go1_s   = 1'b1;
                    end
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_BEAT1: begin
                if (!bus.valid) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        ready_d = (state_d == S_BEAT0) || (state_d == S_BEAT1) || (state_d == S_HOLD);
    end

    // Beat datapath: word selection, store lanes for this beat, and the word presented on rdata
    always_comb begin
        if (go1_s) begin
            beat_idx_s = req_base_s + AW'(1);
            wr_be_s    = lane_be_s[7:4];
            wr_data_s  = lane_data_s[63:32];
        end else begin
            beat_idx_s = req_base_s;
            wr_be_s    = lane_be_s[3:0];
            wr_data_s  = lane_data_s[31:0];
        end
        wr_en_s = (go0_s | go1_s) & (req_be_s != 4'd0) & ~rst;
        if (go0_s | go1_s) begin
            rdata_d = mem[beat_idx_s];
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Sequencer and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            base_q     <= {AW{1'b0}};
            off_q      <= 2'd0;
            wdata_q    <= 32'd0;
            be_q       <= 4'd0;
            two_beat_q <= 1'b0;
            ready_q    <= 1'b0;
            rdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            base_q     <= base_d;
            off_q      <= off_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            two_beat_q <= two_beat_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
        end
    end

    // RAM byte-lane write port; rdata above already sampled the pre-write word
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int j = 0; j < 4; j++) begin
                if (wr_be_s[j]) begin
                    mem[beat_idx_s][8*j +: 8] <= wr_data_s[8*j +: 8];
                end
            end
        end
    end

    assign bus.ready = ready_q;
    assign bus.rdata = rdata_q;
endmodule
